// File: rtl/layer_seq.sv
// ---------------------------------------------------------------------------
// layer_seq : address/strobe sequencer for one fully connected MLP layer.
//
// For each of N_OUT neurons it issues N_IN (weight, input) SRAM read address
// pairs on consecutive cycles. It then drives the matching MAC valid/last
// strobes one cycle later, which accounts for the SRAM read latency. It then
// waits for the MAC/sigmoid path to acknowledge the neuron before moving on.
// A start command launches the layer, and a one-cycle done pulse ends it.
//
// Optional feature macro: LAYER_SEQ_PAUSE_EN adds a `pause` input that
// stretches RUN without changing the product sequence.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous, active-high
//   start      in   begin layer (sampled only in IDLE)
//   pause      in   (LAYER_SEQ_PAUSE_EN only) hold address issue during RUN
//   busy       out  high from the cycle after start is accepted until done
//   done       out  one-cycle pulse after the last neuron is acknowledged
//   w_addr     out  weight SRAM read address (neuron*N_IN + j)
//   x_addr     out  input SRAM read address (j)
//   mac_valid  out  SRAM data for the current product is valid
//   mac_last   out  marks product N_IN-1 of a neuron
//   mac_done   in   MAC/sigmoid acknowledge for the current neuron
//   neuron     out  index of the neuron being processed
// ---------------------------------------------------------------------------
module layer_seq #(
    parameter int unsigned N_IN    = 784,
    parameter int unsigned N_OUT   = 200,
    parameter int unsigned WADDR_W = 18,
    parameter int unsigned IADDR_W = 10,
    parameter int unsigned NIDX_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef LAYER_SEQ_PAUSE_EN
    input  logic               pause,
`endif
    output logic               busy,
    output logic               done,
    output logic [WADDR_W-1:0] w_addr,
    output logic [IADDR_W-1:0] x_addr,
    output logic               mac_valid,
    output logic               mac_last,
    input  logic               mac_done,
    output logic [NIDX_W-1:0]  neuron
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WAIT,
        S_FIN
    } state_e;

    localparam logic [IADDR_W-1:0] X_LAST = IADDR_W'(N_IN - 1);
    localparam logic [NIDX_W-1:0]  N_LAST = NIDX_W'(N_OUT - 1);

    state_e               state_q, state_d;
    logic [WADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [IADDR_W-1:0]   x_addr_q, x_addr_d;
    logic [NIDX_W-1:0]    neuron_q, neuron_d;
    logic                 mac_valid_q, mac_valid_d;
    logic                 mac_last_q, mac_last_d;

    logic                 stall;
    logic                 issue;

`ifdef LAYER_SEQ_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    // An address pair is presented to the SRAMs in every unstalled RUN cycle.
    // x_addr doubles as the product counter j.
    assign issue = (state_q == S_RUN) && !stall;

    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        w_addr_d = w_addr_q;
        x_addr_d = x_addr_q;
        neuron_d = neuron_q;

        // The strobes are the issue flags delayed one register, which lines
        // them up with the data returned by the 1-cycle SRAM read.
        mac_valid_d = issue;
        mac_last_d  = issue && (x_addr_q == X_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    w_addr_d = '0;
                    x_addr_d = '0;
                    neuron_d = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (x_addr_q == X_LAST) begin
                        // Keep the last address on the bus. The weight
                        // counter resumes from it for the next neuron.
                        state_d = S_DRAIN;
                    end else begin
                        x_addr_d = x_addr_q + IADDR_W'(1);
                        w_addr_d = w_addr_q + WADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    if (neuron_q == N_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        state_d  = S_RUN;
                        neuron_d = neuron_q + NIDX_W'(1);
                        x_addr_d = '0;
                        // Running counter replaces neuron*N_IN + j.
                        w_addr_d = w_addr_q + WADDR_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            w_addr_q    <= '0;
            x_addr_q    <= '0;
            neuron_q    <= '0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_addr_q    <= w_addr_d;
            x_addr_q    <= x_addr_d;
            neuron_q    <= neuron_d;
            mac_valid_q <= mac_valid_d;
            mac_last_q  <= mac_last_d;
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WAIT);
    assign done      = (state_q == S_FIN);
    assign w_addr    = w_addr_q;
    assign x_addr    = x_addr_q;
    assign neuron    = neuron_q;
    assign mac_valid = mac_valid_q;
    assign mac_last  = mac_last_q;

endmodule

// File: tb/tb_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_layer_seq : directed self-checking bench for layer_seq.
// DUT A uses N_IN=4, N_OUT=3. DUT B uses N_IN=1, N_OUT=2.
// Inputs change 1 time unit after posedge. Outputs are sampled at the same
// point, so each sample shows the state of the current cycle.
// ---------------------------------------------------------------------------
module tb_layer_seq;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        valid;
        logic        last;
        logic [7:0]  neuron;
        logic [17:0] w;
        logic [9:0]  x;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start_a = 1'b0, mac_done_a = 1'b0, pause_a = 1'b0;
    logic        busy_a, done_a, valid_a, last_a;
    logic [17:0] w_a;
    logic [9:0]  x_a;
    logic [7:0]  n_a;

    logic        start_b = 1'b0, mac_done_b = 1'b0;
    logic        busy_b, done_b, valid_b, last_b;
    logic [17:0] w_b;
    logic [9:0]  x_b;
    logic [7:0]  n_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    layer_seq #(.N_IN(4), .N_OUT(3)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
`ifdef LAYER_SEQ_PAUSE_EN
        .pause     (pause_a),
`endif
        .busy      (busy_a),
        .done      (done_a),
        .w_addr    (w_a),
        .x_addr    (x_a),
        .mac_valid (valid_a),
        .mac_last  (last_a),
        .mac_done  (mac_done_a),
        .neuron    (n_a)
    );

    layer_seq #(.N_IN(1), .N_OUT(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
`ifdef LAYER_SEQ_PAUSE_EN
        .pause     (1'b0),
`endif
        .busy      (busy_b),
        .done      (done_b),
        .w_addr    (w_b),
        .x_addr    (x_b),
        .mac_valid (valid_b),
        .mac_last  (last_b),
        .mac_done  (mac_done_b),
        .neuron    (n_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(input logic b, input logic d, input logic v, input logic l,
                                input int n, input int w, input int x);
        obs_t o;
        o.busy = b; o.done = d; o.valid = v; o.last = l;
        o.neuron = 8'(n); o.w = 18'(w); o.x = 10'(x);
        return o;
    endfunction

    function automatic obs_t get_a();
        return '{busy_a, done_a, valid_a, last_a, n_a, w_a, x_a};
    endfunction

    function automatic obs_t get_b();
        return '{busy_b, done_b, valid_b, last_b, n_b, w_b, x_b};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("busy=%0b done=%0b valid=%0b last=%0b neuron=%0d w=%0d x=%0d",
                         o.busy, o.done, o.valid, o.last, o.neuron, o.w, o.x);
    endfunction

    // Reset state of both instances.
    task automatic test_reset();
        obs_t zero;
        zero = mk(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if (get_a() !== zero) begin
            tests_failed++;
            $display("FAIL reset_a: got %s, want %s", fmt(get_a()), fmt(zero));
        end
        tests_run++;
        if (get_b() !== zero) begin
            tests_failed++;
            $display("FAIL reset_b: got %s, want %s", fmt(get_b()), fmt(zero));
        end
    endtask

    // Full 4x3 layer. The bench acknowledges each neuron `gap` cycles after
    // its mac_last. With `hold`, mac_done and start stay high for the whole
    // run, and both must be ignored outside WAIT and IDLE respectively.
    task automatic test_layer(input int gap, input bit hold, input string name);
        obs_t exp;
        int   cyc;
        start_a = 1'b1;
        mac_done_a = hold;
        tick();
        cyc = 1;
        if (!hold) start_a = 1'b0;
        for (int n = 0; n < 3; n++) begin
            for (int j = 0; j < 4; j++) begin
                exp = mk(1, 0, j > 0, 0, n, n * 4 + j, j);
                tests_run++;
                if (get_a() !== exp) begin
                    tests_failed++;
                    $display("FAIL %s run n%0d j%0d cyc%0d: got %s, want %s",
                             name, n, j, cyc, fmt(get_a()), fmt(exp));
                end
                tick(); cyc++;
            end
            exp = mk(1, 0, 1, 1, n, n * 4 + 3, 3);
            tests_run++;
            if (get_a() !== exp) begin
                tests_failed++;
                $display("FAIL %s drain n%0d cyc%0d: got %s, want %s",
                         name, n, cyc, fmt(get_a()), fmt(exp));
            end
            tick(); cyc++;
            for (int g = 1; g <= gap; g++) begin
                mac_done_a = hold || (g == gap);
                exp = mk(1, 0, 0, 0, n, n * 4 + 3, 3);
                tests_run++;
                if (get_a() !== exp) begin
                    tests_failed++;
                    $display("FAIL %s wait n%0d g%0d cyc%0d: got %s, want %s",
                             name, n, g, cyc, fmt(get_a()), fmt(exp));
                end
                tick(); cyc++;
                mac_done_a = hold;
            end
        end
        // FIN: start asserted here (hold case) must be ignored.
        exp = mk(0, 1, 0, 0, 2, 11, 3);
        tests_run++;
        if (get_a() !== exp) begin
            tests_failed++;
            $display("FAIL %s fin cyc%0d: got %s, want %s", name, cyc, fmt(get_a()), fmt(exp));
        end
        tick();
        start_a = 1'b0;
        mac_done_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp = mk(0, 0, 0, 0, 2, 11, 3);
            tests_run++;
            if (get_a() !== exp) begin
                tests_failed++;
                $display("FAIL %s idle%0d: got %s, want %s", name, k, fmt(get_a()), fmt(exp));
            end
            tick();
        end
    endtask

    // Reset mid-RUN at neuron 1, j=2, then a fresh start from address 0.
    task automatic test_reset_mid_run();
        obs_t exp;
        start_a = 1'b1;
        mac_done_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        exp = mk(1, 0, 1, 0, 1, 6, 2);
        tests_run++;
        if (get_a() !== exp) begin
            tests_failed++;
            $display("FAIL midrun_pre: got %s, want %s", fmt(get_a()), fmt(exp));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mac_done_a = 1'b0;
        exp = mk(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (get_a() !== exp) begin
            tests_failed++;
            $display("FAIL midrun_reset: got %s, want %s", fmt(get_a()), fmt(exp));
        end
        tick();
        tests_run++;
        if (get_a() !== exp) begin
            tests_failed++;
            $display("FAIL midrun_idle: got %s, want %s", fmt(get_a()), fmt(exp));
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp = mk(1, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (get_a() !== exp) begin
            tests_failed++;
            $display("FAIL midrun_restart0: got %s, want %s", fmt(get_a()), fmt(exp));
        end
        tick();
        exp = mk(1, 0, 1, 0, 0, 1, 1);
        tests_run++;
        if (get_a() !== exp) begin
            tests_failed++;
            $display("FAIL midrun_restart1: got %s, want %s", fmt(get_a()), fmt(exp));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // N_IN=1, N_OUT=2: valid and last coincide. The second acknowledge
    // arrives one cycle late to show that WAIT really waits.
    task automatic test_n_in_one();
        obs_t exp_tab [9];
        logic ack_tab [9];
        exp_tab[0] = mk(1, 0, 0, 0, 0, 0, 0); ack_tab[0] = 0; // RUN n0
        exp_tab[1] = mk(1, 0, 1, 1, 0, 0, 0); ack_tab[1] = 0; // DRAIN
        exp_tab[2] = mk(1, 0, 0, 0, 0, 0, 0); ack_tab[2] = 1; // WAIT, ack
        exp_tab[3] = mk(1, 0, 0, 0, 1, 1, 0); ack_tab[3] = 0; // RUN n1
        exp_tab[4] = mk(1, 0, 1, 1, 1, 1, 0); ack_tab[4] = 0; // DRAIN
        exp_tab[5] = mk(1, 0, 0, 0, 1, 1, 0); ack_tab[5] = 0; // WAIT
        exp_tab[6] = mk(1, 0, 0, 0, 1, 1, 0); ack_tab[6] = 1; // WAIT, ack
        exp_tab[7] = mk(0, 1, 0, 0, 1, 1, 0); ack_tab[7] = 0; // FIN
        exp_tab[8] = mk(0, 0, 0, 0, 1, 1, 0); ack_tab[8] = 0; // IDLE
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 9; k++) begin
            mac_done_b = ack_tab[k];
            tests_run++;
            if (get_b() !== exp_tab[k]) begin
                tests_failed++;
                $display("FAIL n_in_one cyc%0d: got %s, want %s", k + 1, fmt(get_b()), fmt(exp_tab[k]));
            end
            tick();
        end
        mac_done_b = 1'b0;
    endtask

`ifdef LAYER_SEQ_PAUSE_EN
    // pause for 3 cycles at j=2: x_addr holds, mac_valid shows a 3-cycle gap.
    task automatic test_pause();
        obs_t exp_tab [8];
        logic pz_tab [8];
        exp_tab[0] = mk(1, 0, 0, 0, 0, 0, 0); pz_tab[0] = 0;
        exp_tab[1] = mk(1, 0, 1, 0, 0, 1, 1); pz_tab[1] = 0;
        exp_tab[2] = mk(1, 0, 1, 0, 0, 2, 2); pz_tab[2] = 1;
        exp_tab[3] = mk(1, 0, 0, 0, 0, 2, 2); pz_tab[3] = 1;
        exp_tab[4] = mk(1, 0, 0, 0, 0, 2, 2); pz_tab[4] = 1;
        exp_tab[5] = mk(1, 0, 0, 0, 0, 2, 2); pz_tab[5] = 0;
        exp_tab[6] = mk(1, 0, 1, 0, 0, 3, 3); pz_tab[6] = 0;
        exp_tab[7] = mk(1, 0, 1, 1, 0, 3, 3); pz_tab[7] = 1; // DRAIN: pause ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pause_a = pz_tab[k];
            tests_run++;
            if (get_a() !== exp_tab[k]) begin
                tests_failed++;
                $display("FAIL pause cyc%0d: got %s, want %s", k + 1, fmt(get_a()), fmt(exp_tab[k]));
            end
            tick();
        end
        pause_a = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_layer(5, 1'b0, "gap5");
        test_layer(1, 1'b1, "back_to_back");
        test_reset_mid_run();
        test_n_in_one();
`ifdef LAYER_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
